// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared decode enums, ALU op codes and opcode constants for rv_core
package rv_core_pkg;

  typedef enum logic [5:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU, CU_XORI, CU_ORI, CU_ANDI,
    CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA,
    CU_OR, CU_AND,
    CU_ERROR
  } cuop_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic is_branch(cuop_t c);
    return (c >= CU_BEQ) && (c <= CU_BGEU);
  endfunction

  function automatic logic is_load(cuop_t c);
    return (c >= CU_LB) && (c <= CU_LHU);
  endfunction

  function automatic logic is_store(cuop_t c);
    return (c >= CU_SB) && (c <= CU_SW);
  endfunction

  function automatic logic is_immop(cuop_t c);
    return (c >= CU_ADDI) && (c <= CU_SRAI);
  endfunction

  function automatic logic is_regop(cuop_t c);
    return (c >= CU_ADD) && (c <= CU_AND);
  endfunction

endpackage

// File: rtl/rv_core_alu.sv
// rtl/rv_core_alu.sv - 32-bit integer ALU, shift amount taken from operand B[4:0]
module rv_core_alu
  import rv_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);

  // evaluate the selected operation; unused codes give zero
  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_core_decode.sv
// rtl/rv_core_decode.sv - instruction decoder: cuOP class, immediate, ALU op and operand-B select
module rv_core_decode
  import rv_core_pkg::*;
(
  input  logic [31:0] instruction,
  output cuop_t       cuop,
  output logic [31:0] imm_out,
  output logic [3:0]  alu_op,
  output logic        alu_src
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  // classify the instruction; anything not explicitly recognised stays ERROR
  always_comb begin
    cuop = CU_ERROR;
    case (opcode)
      OP_LUI:    cuop = CU_LUI;
      OP_AUIPC:  cuop = CU_AUIPC;
      OP_JAL:    cuop = CU_JAL;
      OP_JALR:   if (f3 == 3'd0) cuop = CU_JALR;
      OP_BRANCH: case (f3)
        3'd0: cuop = CU_BEQ;   3'd1: cuop = CU_BNE;
        3'd4: cuop = CU_BLT;   3'd5: cuop = CU_BGE;
        3'd6: cuop = CU_BLTU;  3'd7: cuop = CU_BGEU;
        default: cuop = CU_ERROR;
      endcase
      OP_LOAD: case (f3)
        3'd0: cuop = CU_LB;    3'd1: cuop = CU_LH;   3'd2: cuop = CU_LW;
        3'd4: cuop = CU_LBU;   3'd5: cuop = CU_LHU;
        default: cuop = CU_ERROR;
      endcase
      OP_STORE: case (f3)
        3'd0: cuop = CU_SB;    3'd1: cuop = CU_SH;   3'd2: cuop = CU_SW;
        default: cuop = CU_ERROR;
      endcase
      OP_IMM: case (f3)
        3'd0: cuop = CU_ADDI;  3'd2: cuop = CU_SLTI; 3'd3: cuop = CU_SLTIU;
        3'd4: cuop = CU_XORI;  3'd6: cuop = CU_ORI;  3'd7: cuop = CU_ANDI;
        3'd1: if (f7 == 7'h00) cuop = CU_SLLI;
        default: begin
          if (f7 == 7'h00)      cuop = CU_SRLI;
          else if (f7 == 7'h20) cuop = CU_SRAI;
        end
      endcase
      OP_REG: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: cuop = CU_ADD;  3'd1: cuop = CU_SLL;  3'd2: cuop = CU_SLT;
            3'd3: cuop = CU_SLTU; 3'd4: cuop = CU_XOR;  3'd5: cuop = CU_SRL;
            3'd6: cuop = CU_OR;   default: cuop = CU_AND;
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0)      cuop = CU_SUB;
          else if (f3 == 3'd5) cuop = CU_SRA;
        end
      end
      default: cuop = CU_ERROR;
    endcase
  end

  // pick the immediate format that belongs to the decoded class
  always_comb begin
    imm_out = 32'd0;
    if (cuop == CU_LUI || cuop == CU_AUIPC)
      imm_out = {instruction[31:12], 12'd0};
    else if (cuop == CU_JAL)
      imm_out = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
    else if (is_branch(cuop))
      imm_out = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
    else if (is_store(cuop))
      imm_out = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    else if (cuop == CU_JALR || is_load(cuop) || is_immop(cuop))
      imm_out = {{20{instruction[31]}}, instruction[31:20]};
  end

  // ALU op and operand-B source; address, link and upper-immediate paths all add
  always_comb begin
    alu_op  = is_branch(cuop) ? ALU_SUB : ALU_ADD;
    alu_src = is_load(cuop) || is_store(cuop) || is_immop(cuop) ||
              cuop == CU_LUI || cuop == CU_AUIPC || cuop == CU_JAL || cuop == CU_JALR;
    case (cuop)
      CU_SUB:             alu_op = ALU_SUB;
      CU_SLTI,  CU_SLT:   alu_op = ALU_SLT;
      CU_SLTIU, CU_SLTU:  alu_op = ALU_SLTU;
      CU_XORI,  CU_XOR:   alu_op = ALU_XOR;
      CU_ORI,   CU_OR:    alu_op = ALU_OR;
      CU_ANDI,  CU_AND:   alu_op = ALU_AND;
      CU_SLLI,  CU_SLL:   alu_op = ALU_SLL;
      CU_SRLI,  CU_SRL:   alu_op = ALU_SRL;
      CU_SRAI,  CU_SRA:   alu_op = ALU_SRA;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_regfile.sv
// rtl/rv_regfile.sv - 32x32 register file, two async reads, one write, x0 hardwired to zero
module rv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  waddr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  // clear every register on reset; writes aimed at x0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/rv_core_top.sv
// rtl/rv_core_top.sv - single-cycle RV32I-subset core: PC, data memory and datapath glue
module rv_core_top
  import rv_core_pkg::*;
#(
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instruction,
  output logic [31:0] memload,
  output logic [31:0] aluIn,
  output logic [31:0] aluOut,
  output logic [31:0] immOut,
  output logic [31:0] pc,
  output logic [31:0] writeData,
  output logic        zero,
  output logic        negative,
  output logic [5:0]  cuOP,
  output logic [4:0]  regsel1,
  output logic [4:0]  regsel2,
  output logic [4:0]  w_reg,
  output logic [19:0] imm,
  output logic [31:0] regData1,
  output logic [31:0] regData2,
  output logic [3:0]  aluOP,
  output logic        aluSrc
);

  localparam int DM_AW = $clog2(DMEM_WORDS);

  cuop_t             cu;
  logic [31:0]       alu_a, pc_plus4, pc_next, word, byte_sh, half_sh, sdata;
  logic [3:0]        be;
  logic              taken, rf_we;
  logic [DM_AW-1:0]  dm_idx;
  logic [31:0]       dmem [DMEM_WORDS];

  assign regsel1 = instruction[19:15];
  assign regsel2 = instruction[24:20];
  assign w_reg   = instruction[11:7];
  assign imm     = instruction[31:12];
  assign cuOP    = cu;

  rv_core_decode u_decode (
    .instruction (instruction), .cuop (cu), .imm_out (immOut),
    .alu_op (aluOP), .alu_src (aluSrc)
  );

  rv_regfile u_regfile (
    .clk (clk), .rst (nrst), .raddr1 (regsel1), .raddr2 (regsel2),
    .waddr (w_reg), .we (rf_we), .wdata (writeData),
    .rdata1 (regData1), .rdata2 (regData2)
  );

  assign alu_a = (cu == CU_LUI) ? 32'd0 : (cu == CU_AUIPC) ? pc : regData1;
  assign aluIn = aluSrc ? immOut : regData2;

  rv_core_alu u_alu (.a (alu_a), .b (aluIn), .op (aluOP), .y (aluOut));

  assign zero     = (aluOut == 32'd0);
  assign negative = aluOut[31];

  // branch resolution uses its own comparators rather than the ALU flags
  always_comb begin
    taken = 1'b0;
    case (cu)
      CU_BEQ:  taken = (regData1 == regData2);
      CU_BNE:  taken = (regData1 != regData2);
      CU_BLT:  taken = ($signed(regData1) <  $signed(regData2));
      CU_BGE:  taken = ($signed(regData1) >= $signed(regData2));
      CU_BLTU: taken = (regData1 <  regData2);
      CU_BGEU: taken = (regData1 >= regData2);
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  // next-pc selection: sequential, pc-relative, or register-indirect with bit 0 cleared
  always_comb begin
    pc_next = pc_plus4;
    if (cu == CU_JAL || taken) pc_next = pc + immOut;
    else if (cu == CU_JALR)    pc_next = (regData1 + immOut) & ~32'd1;
  end

  // program counter register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) pc <= PC_RESET;
    else      pc <= pc_next;
  end

  assign dm_idx  = aluOut[DM_AW+1:2];
  assign word    = dmem[dm_idx];
  assign byte_sh = word >> {aluOut[1:0], 3'b000};
  assign half_sh = word >> {aluOut[1], 4'b0000};

  // byte/half lane select and extension of the load result
  always_comb begin
    memload = 32'd0;
    case (cu)
      CU_LB:   memload = {{24{byte_sh[7]}}, byte_sh[7:0]};
      CU_LH:   memload = {{16{half_sh[15]}}, half_sh[15:0]};
      CU_LW:   memload = word;
      CU_LBU:  memload = {24'd0, byte_sh[7:0]};
      CU_LHU:  memload = {16'd0, half_sh[15:0]};
      default: memload = 32'd0;
    endcase
  end

  // store lane enables and replicated store data
  always_comb begin
    be    = 4'b0000;
    sdata = regData2;
    case (cu)
      CU_SB: begin be = 4'b0001 << aluOut[1:0]; sdata = {4{regData2[7:0]}}; end
      CU_SH: begin be = aluOut[1] ? 4'b1100 : 4'b0011; sdata = {2{regData2[15:0]}}; end
      CU_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // data memory lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) dmem[dm_idx][8*b +: 8] <= sdata[8*b +: 8];
  end

  assign rf_we = is_load(cu) || is_immop(cu) || is_regop(cu) ||
                 cu == CU_LUI || cu == CU_AUIPC || cu == CU_JAL || cu == CU_JALR;

  assign writeData = is_load(cu) ? memload :
                     (cu == CU_JAL || cu == CU_JALR) ? pc_plus4 : aluOut;

endmodule

// File: tb/tb_rv_core_top.sv
// tb/tb_rv_core_top.sv - directed and random instruction bench for rv_core_top with an ISA-level model
module tb_rv_core_top;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] instruction;
  logic [31:0] memload, aluIn, aluOut, immOut, pc, writeData, regData1, regData2;
  logic        zero, negative, aluSrc;
  logic [5:0]  cuOP;
  logic [4:0]  regsel1, regsel2, w_reg;
  logic [19:0] imm;
  logic [3:0]  aluOP;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

  logic [31:0] e_npc, e_wd, e_ld, e_word;
  logic        e_wen, e_mwe, e_err;
  logic [4:0]  e_rd;
  logic [5:0]  e_widx;

  rv_core_top #(.DMEM_WORDS(64), .PC_RESET(32'h0)) dut (
    .clk (clk), .nrst (nrst), .instruction (instruction),
    .memload (memload), .aluIn (aluIn), .aluOut (aluOut), .immOut (immOut),
    .pc (pc), .writeData (writeData), .zero (zero), .negative (negative),
    .cuOP (cuOP), .regsel1 (regsel1), .regsel2 (regsel2), .w_reg (w_reg),
    .imm (imm), .regData1 (regData1), .regData2 (regData2),
    .aluOP (aluOP), .aluSrc (aluSrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [31:0] r;
    logic [2:0]  lf3 [5];
    logic [2:0]  bf3 [6];
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    i12 = 12'($urandom);
    r   = $urandom;
    case ($urandom_range(0, 9))
      1: rand_instr = enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      2: rand_instr = {r[31:12], rd, r[5] ? 7'h37 : 7'h17};
      3: rand_instr = enc_i(i12, rs1, lf3[$urandom_range(0, 4)], rd, 7'h03);
      4: rand_instr = enc_s(i12, rs2, rs1, 3'($urandom_range(0, 2)));
      5: rand_instr = enc_b({i12, 1'b0}, rs2, rs1, bf3[$urandom_range(0, 5)]);
      6: rand_instr = enc_j({r[19:0], 1'b0}, rd);
      7: rand_instr = enc_i(i12, rs1, 3'd0, rd, 7'h67);
      8: rand_instr = r;
      default: begin
        if (f3 == 3'd1)      i12 = {7'h00, i12[4:0]};
        else if (f3 == 3'd5) i12 = {r[0] ? 7'h20 : 7'h00, i12[4:0]};
        rand_instr = enc_i(i12, rs1, f3, rd, 7'h13);
      end
    endcase
  endfunction

  // ISA-level reference: computes the architectural effect of one instruction
  task automatic model_eval(input logic [31:0] ins);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, ii, is, ib, iu, ij, addr, w, opb;
    logic        tk, bvalid;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a  = m_reg[ins[19:15]];
    b  = m_reg[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'd0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e_rd = ins[11:7];
    e_npc = m_pc + 32'd4; e_wen = 1'b0; e_wd = 32'd0; e_ld = 32'd0;
    e_mwe = 1'b0; e_err = 1'b1; e_widx = 6'd0; e_word = 32'd0;
    case (opc)
      7'h37: begin e_err = 0; e_wen = 1; e_wd = iu; end
      7'h17: begin e_err = 0; e_wen = 1; e_wd = m_pc + iu; end
      7'h6f: begin e_err = 0; e_wen = 1; e_wd = m_pc + 32'd4; e_npc = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin
        e_err = 0; e_wen = 1; e_wd = m_pc + 32'd4; e_npc = (a + ii) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        bvalid = 1'b1; tk = 1'b0;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: bvalid = 1'b0;
        endcase
        if (bvalid) begin
          e_err = 0;
          if (tk) e_npc = m_pc + ib;
        end
      end
      7'h03: begin
        addr = a + ii; w = m_mem[addr[7:2]];
        e_err = 0; e_wen = 1;
        case (f3)
          3'd0: e_ld = 32'($signed(w[int'(addr[1:0])*8 +: 8]));
          3'd1: e_ld = 32'($signed(w[int'(addr[1])*16 +: 16]));
          3'd2: e_ld = w;
          3'd4: e_ld = {24'd0, w[int'(addr[1:0])*8 +: 8]};
          3'd5: e_ld = {16'd0, w[int'(addr[1])*16 +: 16]};
          default: begin e_err = 1; e_wen = 0; end
        endcase
        e_wd = e_ld;
      end
      7'h23: begin
        addr = a + is; w = m_mem[addr[7:2]];
        e_err = 0;
        case (f3)
          3'd0: w[int'(addr[1:0])*8 +: 8] = b[7:0];
          3'd1: w[int'(addr[1])*16 +: 16] = b[15:0];
          3'd2: w = b;
          default: e_err = 1;
        endcase
        e_mwe = !e_err; e_widx = addr[7:2]; e_word = w;
      end
      7'h13, 7'h33: begin
        opb = (opc == 7'h13) ? ii : b;
        e_err = 0;
        case (f3)
          3'd0: if (opc == 7'h13 || f7 == 7'h00) e_wd = a + opb;
                else if (f7 == 7'h20)            e_wd = a - opb;
                else e_err = 1;
          3'd1: if (f7 == 7'h00) e_wd = a << opb[4:0]; else e_err = 1;
          3'd5: if (f7 == 7'h00)      e_wd = a >> opb[4:0];
                else if (f7 == 7'h20) e_wd = 32'($signed(a) >>> opb[4:0]);
                else e_err = 1;
          default: begin
            if (opc == 7'h33 && f7 != 7'h00) e_err = 1;
            case (f3)
              3'd2: e_wd = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
              3'd3: e_wd = (a < opb) ? 32'd1 : 32'd0;
              3'd4: e_wd = a ^ opb;
              3'd6: e_wd = a | opb;
              default: e_wd = a & opb;
            endcase
          end
        endcase
        e_wen = !e_err;
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [31:0] ins);
    instruction = ins;
    #2;
    model_eval(ins);
    chk("pc", pc, m_pc);
    chk("rs1_data", regData1, m_reg[ins[19:15]]);
    chk("rs2_data", regData2, m_reg[ins[24:20]]);
    chk("memload", memload, e_ld);
    chk("is_error", {31'd0, cuOP == 6'd38}, {31'd0, e_err});
    if (e_wen) chk("write_data", writeData, e_wd);
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (e_wen && e_rd != 5'd0) m_reg[e_rd] = e_wd;
    if (e_mwe) m_mem[e_widx] = e_word;
    m_pc = e_npc;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  task automatic check_cleared();
    chk("reset_pc", pc, 32'h0);
    for (int i = 1; i < 32; i++) begin
      instruction = enc_r(7'h00, 5'(i), 5'(i), 3'd0, 5'd0);
      #1;
      chk($sformatf("reset_x%0d", i), regData1, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] p;
    nrst = 1'b1;
    instruction = 32'h0000_0013;
    model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared();
    instruction = 32'h0000_0013;
    nrst = 1'b0;

    // addi x1,x0,1000
    drive(32'h3e80_0093);
    chk("addi_cuop", {26'd0, cuOP}, 32'd18);
    chk("addi_alusrc", {31'd0, aluSrc}, 32'd1);
    chk("addi_imm", immOut, 32'h3E8);
    chk("addi_alu", aluOut, 32'h3E8);
    commit();
    chk("addi_pc", pc, 32'd4);

    // addi x2,x0,-2000
    drive(32'h8300_0113);
    chk("addi_neg_imm", immOut, 32'hFFFF_F830);
    chk("addi_neg_flag", {31'd0, negative}, 32'd1);
    chk("addi_neg_wd", writeData, 32'hFFFF_F830);
    commit();

    drive(32'h3e90_6193);
    chk("ori_wd", writeData, 32'h3E9);
    commit();
    drive(32'h3f31_f213);
    chk("andi_rs1", regData1, 32'h3E9);
    chk("andi_wd", writeData, 32'h3E1);
    commit();

    drive(32'h7d00_0113); commit();           // x2 = 2000
    drive(32'hc180_0193); commit();           // x3 = -1000

    p = pc;
    drive(32'h0011_1263);
    chk("bne_cuop", {26'd0, cuOP}, 32'd5);
    chk("bne_sel", {22'd0, regsel1, regsel2}, {22'd0, 5'd2, 5'd1});
    commit();
    chk("bne_pc", pc, p + 32'd4);

    drive(32'h0030_8263);
    chk("beq_cuop", {26'd0, cuOP}, 32'd4);
    chk("beq_sel", {22'd0, regsel1, regsel2}, {22'd0, 5'd1, 5'd3});
    commit();

    drive(32'h0011_c263);
    chk("blt_cuop", {26'd0, cuOP}, 32'd6);
    chk("blt_sel", {22'd0, regsel1, regsel2}, {22'd0, 5'd3, 5'd1});
    commit();

    drive(32'h0020_d263);
    chk("bge_cuop", {26'd0, cuOP}, 32'd7);
    chk("bge_sel", {22'd0, regsel1, regsel2}, {22'd0, 5'd1, 5'd2});
    commit();

    p = pc;
    drive(32'h0040_026f);
    chk("jal_cuop", {26'd0, cuOP}, 32'd2);
    chk("jal_link", writeData, p + 32'd4);
    commit();
    chk("jal_pc", pc, p + 32'd4);

    p = pc;
    drive(32'h3e80_8467);
    chk("jalr_rs1", regData1, 32'd1000);
    chk("jalr_link", writeData, p + 32'd4);
    commit();
    chk("jalr_pc", pc, 32'd2000);

    // give every data-memory word a known value before random loads
    for (int w = 0; w < 64; w++) begin
      drive(enc_i(12'($urandom), 5'd0, 3'd0, 5'd5, 7'h13)); commit();
      drive(enc_s(12'(w * 4), 5'd5, 5'd0, 3'd2)); commit();
    end

    for (int n = 0; n < 300; n++) begin
      drive(rand_instr());
      commit();
    end

    // asynchronous reset between clock edges
    #3;
    nrst = 1'b1;
    #1;
    check_cleared();
    @(posedge clk);
    #1;
    nrst = 1'b0;
    model_reset();

    for (int n = 0; n < 150; n++) begin
      drive(rand_instr());
      commit();
    end
    chk("final_pc", pc, m_pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
